// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : imem_pkg
// Purpose  : Shared geometry and FSM encoding for the instruction-memory loader
// Revision : 1.0
// ============================================================================
package imem_pkg;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BIDX_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RECV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_ram
// Purpose  : DEPTH x 32 instruction RAM, synchronous write, asynchronous read
// Revision : 1.0
// ============================================================================
module imem_ram
    import imem_pkg::*;
#(
    parameter int ADDR_W = imem_pkg::ADDR_W,
    parameter int DEPTH  = imem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DEPTH];

    // Contents are deliberately left unreset so a reset never wipes a program.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Packs a byte stream little-endian into words and loads the IMEM
// Revision : 1.0
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = imem_pkg::ADDR_W,
    parameter int DEPTH  = imem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_words,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              core_run,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_one       = (ADDR_W+1)'(1);
    localparam logic [BIDX_W-1:0] c_last_bidx = BIDX_W'(3);

    state_t              r_state;
    logic [ADDR_W:0]     r_count;
    logic [BIDX_W-1:0]   r_bidx;
    logic [ADDR_W-1:0]   r_waddr;
    logic [23:0]         r_bytes;
    logic                r_err;

    logic                w_legal;
    logic                w_ready;
    logic                w_xfer;
    logic                w_we;
    logic                w_last;
    logic [31:0]         w_wdata;

    always_comb begin
        w_legal = (load_words != '0) && (load_words <= c_depth);
        w_ready = (r_state == ST_RECV);
        // A start pulse wins over a byte offered in the same cycle.
        w_xfer  = w_ready && in_valid && !load_start;
        w_we    = w_xfer && (r_bidx == c_last_bidx);
        w_last  = ({1'b0, r_waddr} == (r_count - c_one));
        w_wdata = {in_byte, r_bytes};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_bidx  <= '0;
            r_waddr <= '0;
            r_bytes <= '0;
            r_err   <= 1'b0;
        end else if (load_start) begin
            r_bidx  <= '0;
            r_waddr <= '0;
            r_bytes <= '0;
            if (w_legal) begin
                r_count <= load_words;
                r_err   <= 1'b0;
                r_state <= ST_RECV;
            end else begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
            end
        end else if (w_xfer) begin
            if (r_bidx == c_last_bidx) begin
                r_bidx  <= '0;
                r_waddr <= r_waddr + 1'b1;
                if (w_last) begin
                    r_state <= ST_DONE;
                end
            end else begin
                case (r_bidx)
                    2'd0:    r_bytes[7:0]   <= in_byte;
                    2'd1:    r_bytes[15:8]  <= in_byte;
                    default: r_bytes[23:16] <= in_byte;
                endcase
                r_bidx <= r_bidx + 1'b1;
            end
        end
    end

    assign in_ready  = w_ready;
    assign load_done = (r_state == ST_DONE);
    assign core_run  = (r_state == ST_DONE);
    assign load_err  = r_err;

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_waddr),
        .wdata (w_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Scoreboard-driven bench for the instruction-memory loader
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_words;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        load_done;
    logic        load_err;
    logic        core_run;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_words (load_words),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_done  (load_done),
        .load_err   (load_err),
        .core_run   (core_run),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] n);
        load_words = n;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_byte  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; load_words = '0;
        in_byte = '0; in_valid = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        n_chk++; if ({in_ready, load_done, load_err, core_run} !== 4'b0000) $display("FAIL reset_outputs: got %b want 0000", {in_ready, load_done, load_err, core_run}); else n_pass++;
        tick();
        n_chk++; if (in_ready !== 1'b0) $display("FAIL idle_ready: got %b want 0", in_ready); else n_pass++;
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        exp_t e;
        w = 32'h00500513;
        start(8'd1);
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (in_ready !== 1'b1 || load_done !== 1'b0) $display("FAIL single_ready_b%0d: got ready=%b done=%b want ready=1 done=0", i, in_ready, load_done); else n_pass++;
            in_byte  = w[8*i +: 8];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        exp_q.push_back('{addr: 7'd0, data: w});
        n_chk++; if ({load_done, core_run, in_ready} !== 3'b110) $display("FAIL single_done: got done/run/ready=%b want 110", {load_done, core_run, in_ready}); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            n_chk++; if (rd_data !== e.data) $display("FAIL single_rd[%0d]: got %h want %h", e.addr, rd_data, e.data); else n_pass++;
        end
    endtask

    task automatic test_full_load();
        exp_t e;
        start(8'd128);
        n_chk++; if (in_ready !== 1'b1) $display("FAIL full_ready: got %b want 1", in_ready); else n_pass++;
        for (int i = 0; i < 128; i++) begin
            if (i == 127) begin
                n_chk++; if (load_done !== 1'b0) $display("FAIL full_early_done: got %b want 0", load_done); else n_pass++;
            end
            send_word(32'(i), 1'b1);
            exp_q.push_back('{addr: 7'(i), data: 32'(i)});
        end
        n_chk++; if ({load_done, core_run} !== 2'b11) $display("FAIL full_done: got %b want 11", {load_done, core_run}); else n_pass++;
        // Bytes offered after completion must be ignored.
        send_word(32'hFFFF_FFFF, 1'b0);
        n_chk++; if (in_ready !== 1'b0 || load_done !== 1'b1) $display("FAIL full_hold: got ready=%b done=%b want ready=0 done=1", in_ready, load_done); else n_pass++;
        rd_addr = 7'd127;
        @(negedge clk);
        n_chk++; if (rd_data !== 32'h0000007F) $display("FAIL full_rd127: got %h want 0000007f", rd_data); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            n_chk++; if (rd_data !== e.data) $display("FAIL full_rd[%0d]: got %h want %h", e.addr, rd_data, e.data); else n_pass++;
        end
    endtask

    task automatic test_illegal_count();
        start(8'd0);
        n_chk++; if ({load_err, in_ready, load_done, core_run} !== 4'b1000) $display("FAIL illegal0: got err/ready/done/run=%b want 1000", {load_err, in_ready, load_done, core_run}); else n_pass++;
        start(8'd129);
        n_chk++; if ({load_err, in_ready} !== 2'b10) $display("FAIL illegal129: got err/ready=%b want 10", {load_err, in_ready}); else n_pass++;
        start(8'd2);
        n_chk++; if ({load_err, in_ready} !== 2'b01) $display("FAIL legal_after_err: got err/ready=%b want 01", {load_err, in_ready}); else n_pass++;
    endtask

    task automatic test_restart();
        logic [31:0] w;
        exp_t e;
        w = 32'h11223344;
        start(8'd3);
        send_word(32'hA1A2A3A4, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        load_words = 8'd1;
        load_start = 1'b1;
        in_byte    = 8'hEE;
        in_valid   = 1'b1;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8], 1'b0);
        n_chk++; if (load_done !== 1'b0) $display("FAIL restart_early_done: got %b want 0", load_done); else n_pass++;
        send_byte(w[31:24], 1'b0);
        n_chk++; if ({load_done, core_run} !== 2'b11) $display("FAIL restart_done: got %b want 11", {load_done, core_run}); else n_pass++;
        exp_q.push_back('{addr: 7'd0, data: w});
        exp_q.push_back('{addr: 7'd1, data: 32'd1});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            n_chk++; if (rd_data !== e.data) $display("FAIL restart_rd[%0d]: got %h want %h", e.addr, rd_data, e.data); else n_pass++;
        end
    endtask

    task automatic test_reset_midload();
        exp_t e;
        start(8'd2);
        send_word(32'hCAFEF00D, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if ({in_ready, load_done, load_err, core_run} !== 4'b0000) $display("FAIL midreset_outputs: got %b want 0000", {in_ready, load_done, load_err, core_run}); else n_pass++;
        exp_q.push_back('{addr: 7'd0, data: 32'hCAFEF00D});
        exp_q.push_back('{addr: 7'd1, data: 32'd1});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            rd_addr = e.addr;
            @(negedge clk);
            n_chk++; if (rd_data !== e.data) $display("FAIL midreset_rd[%0d]: got %h want %h", e.addr, rd_data, e.data); else n_pass++;
        end
    endtask

    task automatic test_read_during_write();
        start(8'd1);
        rd_addr = 7'd0;
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        in_byte  = 8'hDE;
        in_valid = 1'b1;
        #1;
        n_chk++; if (rd_data !== 32'hCAFEF00D) $display("FAIL rdw_before: got %h want cafef00d", rd_data); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_chk++; if (rd_data !== 32'hDEADBEEF) $display("FAIL rdw_after: got %h want deadbeef", rd_data); else n_pass++;
        n_chk++; if (load_done !== 1'b1) $display("FAIL rdw_done: got %b want 1", load_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_load();
        test_illegal_count();
        test_restart();
        test_reset_midload();
        test_read_during_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
